// File: rtl/miner_pkg.sv
// Shared constants and types for the work-loading shift interface.
// The receiver's timer uses the same MID_LAST / ALL_LAST constants.
package miner_pkg;

  localparam int WORD_W    = 32;
  localparam int MID_WORDS = 8;
  localparam int REM_WORDS = 16;
  localparam int CNT_W     = 5;

  localparam int MID_LAST  = MID_WORDS - 1;
  localparam int ALL_LAST  = MID_WORDS + REM_WORDS - 1;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT_MID,
    SHIFT_REM
  } tx_state_t;

endpackage

// File: rtl/work_shift_tx_cnt.sv
// Generic up-counter with synchronous clear (priority) and enable.
module work_shift_tx_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/work_shift_tx.sv
// Transmit end of the work-loading shift interface: latches one work unit,
// marks job start, then serializes midstate words followed by block words.
module work_shift_tx
  import miner_pkg::*;
#(
  parameter int WORD_W    = miner_pkg::WORD_W,
  parameter int MID_WORDS = miner_pkg::MID_WORDS,
  parameter int REM_WORDS = miner_pkg::REM_WORDS,
  parameter int CNT_W     = miner_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          work_valid,
  output logic                          work_ready,
  input  logic [MID_WORDS*WORD_W-1:0]   midstate_in,
  input  logic [REM_WORDS*WORD_W-1:0]   block_in,
  input  logic                          rx_ready,
  output logic                          start_found,
  output logic                          shift_valid,
  output logic [WORD_W-1:0]             shift_data,
  output logic                          midstate_shifts_done,
  output logic                          remaining_shifts_done,
  output logic                          busy
);

  localparam int SR_W = WORD_W * (MID_WORDS + REM_WORDS);
  localparam logic [CNT_W-1:0] MID_LAST_C = CNT_W'(MID_WORDS - 1);
  localparam logic [CNT_W-1:0] ALL_LAST_C = CNT_W'(MID_WORDS + REM_WORDS - 1);

  tx_state_t        state_q;
  logic [SR_W-1:0]  sr_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             beat;
  logic             mid_last;
  logic             all_last;

  // All control outputs decode directly from the state register.
  assign work_ready  = (state_q == IDLE);
  assign start_found = (state_q == START);
  assign shift_valid = (state_q == SHIFT_MID) || (state_q == SHIFT_REM);
  assign busy        = (state_q != IDLE);
  assign shift_data  = sr_q[SR_W-1 -: WORD_W];

  assign accept = work_valid & work_ready;
  // A reset cycle must never count as a beat, so a job aborted on its last word emits no strobe.
  assign beat   = shift_valid & rx_ready & n_rst;

  assign mid_last = (state_q == SHIFT_MID) && (cnt == MID_LAST_C);
  assign all_last = (state_q == SHIFT_REM) && (cnt == ALL_LAST_C);

  assign midstate_shifts_done  = beat & mid_last;
  assign remaining_shifts_done = beat & all_last;

  work_shift_tx_cnt #(
    .W (CNT_W)
  ) u_word_cnt (
    .clk   (clk),
    .clr_i (accept | ~n_rst),
    .en_i  (beat),
    .cnt_o (cnt)
  );

  // NOTE: the shift register is cleared on reset so shift_data reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sr_q    <= {midstate_in, block_in};
            state_q <= START;
          end
        end
        START: begin
          state_q <= SHIFT_MID;
        end
        SHIFT_MID: begin
          if (beat) begin
            sr_q <= {sr_q[SR_W-WORD_W-1:0], {WORD_W{1'b0}}};
            if (mid_last) begin
              state_q <= SHIFT_REM;
            end
          end
        end
        SHIFT_REM: begin
          if (beat) begin
            sr_q <= {sr_q[SR_W-WORD_W-1:0], {WORD_W{1'b0}}};
            if (all_last) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_work_shift_tx.sv
// Self-checking bench for work_shift_tx: queue-based job model, receiver-timer
// loopback, and directed timing scenarios with literal expectations.
module tb_work_shift_tx;
  import miner_pkg::*;

  localparam int MID_W = MID_WORDS * WORD_W;
  localparam int BLK_W = REM_WORDS * WORD_W;

  logic             clk;
  logic             n_rst;
  logic             work_valid;
  logic             work_ready;
  logic [MID_W-1:0] midstate_in;
  logic [BLK_W-1:0] block_in;
  logic             rx_ready;
  logic             start_found;
  logic             shift_valid;
  logic [WORD_W-1:0] shift_data;
  logic             midstate_shifts_done;
  logic             remaining_shifts_done;
  logic             busy;

  work_shift_tx dut (
    .clk                   (clk),
    .n_rst                 (n_rst),
    .work_valid            (work_valid),
    .work_ready            (work_ready),
    .midstate_in           (midstate_in),
    .block_in              (block_in),
    .rx_ready              (rx_ready),
    .start_found           (start_found),
    .shift_valid           (shift_valid),
    .shift_data            (shift_data),
    .midstate_shifts_done  (midstate_shifts_done),
    .remaining_shifts_done (remaining_shifts_done),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job model: a pending start marker, then a queue of the 24 words still owed.
  word_t   m_q[$];
  bit      m_busy  = 0;
  bit      m_start = 0;
  bit      m_valid = 0;

  int      acc_q[$];
  int      start_q[$];
  int      mid_cyc    = -1;
  int      rem_cyc    = -1;
  int      rem_count  = 0;
  int      ready_rise = -1;
  bit      prev_ready = 0;
  word_t   data_at[int];

  // Receiver-side timer, driven only by start_found and accepted beats.
  bit      rx_on  = 0;
  int      rx_cnt = 0;

  always @(negedge clk) begin
    logic exp_sv;
    logic exp_mid;
    logic exp_rem;
    if (m_valid) begin
      exp_sv  = m_busy && !m_start;
      exp_mid = exp_sv && rx_ready && n_rst && (m_q.size() == REM_WORDS + 1);
      exp_rem = exp_sv && rx_ready && n_rst && (m_q.size() == 1);
      check("work_ready",  32'(work_ready),  32'(!m_busy));
      check("busy",        32'(busy),        32'(m_busy));
      check("start_found", 32'(start_found), 32'(m_start));
      check("shift_valid", 32'(shift_valid), 32'(exp_sv));
      check("mid_done",    32'(midstate_shifts_done),  32'(exp_mid));
      check("rem_done",    32'(remaining_shifts_done), 32'(exp_rem));
      if (exp_sv) check("shift_data", shift_data, m_q[0]);
    end

    if (start_found === 1'b1) start_q.push_back(cyc);
    if (midstate_shifts_done === 1'b1) mid_cyc = cyc;
    if (remaining_shifts_done === 1'b1) begin
      rem_cyc = cyc;
      rem_count++;
    end
    if (shift_valid === 1'b1) data_at[cyc] = shift_data;
    if (work_ready === 1'b1 && !prev_ready) ready_rise = cyc;
    prev_ready = (work_ready === 1'b1);

    if (!n_rst) begin
      rx_cnt = 0;
    end else if (start_found === 1'b1) begin
      rx_cnt = 0;
    end else if (shift_valid === 1'b1 && rx_ready) begin
      if (rx_on) begin
        check("rx_mid_timer", 32'(midstate_shifts_done),  32'(rx_cnt == MID_LAST));
        check("rx_rem_timer", 32'(remaining_shifts_done), 32'(rx_cnt == ALL_LAST));
      end
      rx_cnt++;
    end

    if (!n_rst) begin
      m_q.delete();
      m_busy  = 0;
      m_start = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (work_valid) begin
          acc_q.push_back(cyc);
          for (int i = 0; i < MID_WORDS; i++) m_q.push_back(midstate_in[MID_W-1-i*WORD_W -: WORD_W]);
          for (int i = 0; i < REM_WORDS; i++) m_q.push_back(block_in[BLK_W-1-i*WORD_W -: WORD_W]);
          m_busy  = 1;
          m_start = 1;
        end
      end else if (m_start) begin
        m_start = 0;
      end else if (rx_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t get_data(input int c);
    if (data_at.exists(c)) return data_at[c];
    return 'x;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < MID_WORDS; i++) midstate_in[i*WORD_W +: WORD_W] = $urandom;
    for (int i = 0; i < REM_WORDS; i++) block_in[i*WORD_W +: WORD_W] = $urandom;
  endtask

  // Launches one job from IDLE and runs 34 cycles with up to two stall windows.
  task automatic run_job(input logic [MID_W-1:0] m, input logic [BLK_W-1:0] b,
                         input int s1, input int l1, input int s2, input int l2,
                         input bit scramble, output int t);
    midstate_in = m;
    block_in    = b;
    work_valid  = 1'b1;
    rx_ready    = 1'b1;
    @(negedge clk);
    t = cyc;
    tick();
    work_valid = 1'b0;
    check("accept_cycle", 32'(acc_q.size() > 0 ? acc_q[$] : -1), 32'(t));
    for (int k = 1; k <= 34; k++) begin
      rx_ready = !((k >= s1 && k < s1 + l1) || (k >= s2 && k < s2 + l2));
      if (scramble) scramble_inputs();
      tick();
    end
    rx_ready = 1'b1;
  endtask

  task automatic check_plain_timing(input string tag, input int t);
    check({tag, "_start_off"}, 32'(start_q[$] - t), 32'd1);
    check({tag, "_mid_off"},   32'(mid_cyc - t),    32'd9);
    check({tag, "_rem_off"},   32'(rem_cyc - t),    32'd25);
    check({tag, "_ready_off"}, 32'(ready_rise - t), 32'd26);
    check({tag, "_w0"},        get_data(t + 2),     32'h0000_0001);
    check({tag, "_w7"},        get_data(t + 9),     32'h0000_0008);
    check({tag, "_w8"},        get_data(t + 10),    32'h0000_0101);
    check({tag, "_w23"},       get_data(t + 25),    32'h0000_0110);
  endtask

  initial begin
    logic [MID_W-1:0] m1;
    logic [BLK_W-1:0] b1;
    int t;
    int rc_before;
    int guard;

    for (int i = 0; i < MID_WORDS; i++) m1[MID_W-1-i*WORD_W -: WORD_W] = WORD_W'(i + 1);
    for (int i = 0; i < REM_WORDS; i++) b1[BLK_W-1-i*WORD_W -: WORD_W] = WORD_W'(32'h101 + i);

    n_rst       = 1'b0;
    work_valid  = 1'b0;
    rx_ready    = 1'b0;
    midstate_in = '0;
    block_in    = '0;
    tick();
    tick();
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_work_ready",  32'(work_ready),  32'd1);
    check("rst_shift_valid", 32'(shift_valid), 32'd0);
    check("rst_start",       32'(start_found), 32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_shift_data",  shift_data,       32'd0);
    tick();

    // Plain job, receiver always ready.
    run_job(m1, b1, 0, 0, 0, 0, 1'b0, t);
    check_plain_timing("t1", t);

    // Stalls: 3 cycles on word 5, 1 cycle on word 23.
    run_job(m1, b1, 7, 3, 28, 1, 1'b0, t);
    check("t2_mid_off",   32'(mid_cyc - t),    32'd12);
    check("t2_rem_off",   32'(rem_cyc - t),    32'd29);
    check("t2_ready_off", 32'(ready_rise - t), 32'd30);
    check("t2_w5_first",  get_data(t + 7),     32'h0000_0006);
    check("t2_w5_last",   get_data(t + 10),    32'h0000_0006);
    check("t2_w6",        get_data(t + 11),    32'h0000_0007);
    check("t2_w23_hold",  get_data(t + 28),    32'h0000_0110);
    check("t2_w23_beat",  get_data(t + 29),    32'h0000_0110);

    // work_valid held high: jobs must not overlap.
    acc_q.delete();
    start_q.delete();
    midstate_in = m1;
    block_in    = b1;
    rx_ready    = 1'b1;
    work_valid  = 1'b1;
    repeat (60) tick();
    work_valid = 1'b0;
    repeat (30) tick();
    check("t3_accepts", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 2 && start_q.size() >= 2) begin
      check("t3_accept_gap", 32'(acc_q[1] - acc_q[0]),   32'd26);
      check("t3_start2_off", 32'(start_q[1] - acc_q[1]), 32'd1);
      check("t3_start_gap",  32'(start_q[1] - start_q[0]), 32'd26);
    end

    // Reset during SHIFT_REM after word 12 has been accepted.
    midstate_in = m1;
    block_in    = b1;
    work_valid  = 1'b1;
    rx_ready    = 1'b1;
    @(negedge clk);
    t = cyc;
    tick();
    work_valid = 1'b0;
    repeat (14) tick();
    check("t4_word13_on_bus", shift_data, 32'h0000_0106);
    rc_before = rem_count;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    @(negedge clk);
    check("t4_work_ready",  32'(work_ready),  32'd1);
    check("t4_shift_valid", 32'(shift_valid), 32'd0);
    check("t4_start",       32'(start_found), 32'd0);
    check("t4_busy",        32'(busy),        32'd0);
    check("t4_shift_data",  shift_data,       32'd0);
    repeat (5) tick();
    check("t4_no_rem_strobe", 32'(rem_count), 32'(rc_before));
    run_job(m1, b1, 0, 0, 0, 0, 1'b0, t);
    check_plain_timing("t4b", t);

    // Inputs change every cycle after the accept.
    run_job(m1, b1, 0, 0, 0, 0, 1'b1, t);
    check("t5_w0",  get_data(t + 2),  32'h0000_0001);
    check("t5_w12", get_data(t + 14), 32'h0000_0105);
    check("t5_w23", get_data(t + 25), 32'h0000_0110);

    // Loopback against the receiver timer over 100 randomly stalled jobs.
    rx_on      = 1'b1;
    rc_before  = rem_count;
    work_valid = 1'b1;
    guard      = 0;
    while ((rem_count - rc_before) < 100 && guard < 20000) begin
      rx_ready = 1'($urandom_range(0, 1));
      scramble_inputs();
      tick();
      guard++;
    end
    check("t6_jobs_done", 32'(rem_count - rc_before), 32'd100);
    work_valid = 1'b0;
    rx_ready   = 1'b1;
    repeat (30) tick();
    rx_on = 1'b0;
    check("t6_idle_after", 32'(work_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/work_shift_tx.md
Name: work_shift_tx

Overview:
- Transmit end of the work-loading shift interface into a hashing core.
- Accepts one parallel work unit on a valid/ready handshake: 256-bit midstate plus 512-bit second message block.
- Signals start of job with a one-cycle start_found, then serializes 8 midstate words followed by 16 block words, one 32-bit word per accepted beat.
- Produces the same midstate/remaining completion strobes the receiving core's timer generates, so the two ends can be cross-checked.

Parameters:
- WORD_W, 32, width of one shifted word
- MID_WORDS, 8, number of midstate words (MID_WORDS*WORD_W = midstate_in width)
- REM_WORDS, 16, number of block words (REM_WORDS*WORD_W = block_in width)
- CNT_W, 5, word-index counter width; must hold MID_WORDS+REM_WORDS-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  synchronous active-low reset
- work_valid  in  1  upstream work unit available
- work_ready  out  1  block can accept a work unit
- midstate_in  in  256  midstate, word 0 = [255:224]
- block_in  in  512  second block, word 0 = [511:480]
- rx_ready  in  1  receiver accepts shift_data this cycle
- start_found  out  1  one-cycle job-start marker to the receiver
- shift_valid  out  1  shift_data holds a valid word
- shift_data  out  32  current word
- midstate_shifts_done  out  1  pulse on acceptance of the last midstate word
- remaining_shifts_done  out  1  pulse on acceptance of the last block word
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is n_rst, synchronous and active-low.
- Reset values: state IDLE, counter 0, shift register 0. All outputs 0, except work_ready, which is 1 once in IDLE.
- Reset mid-job aborts immediately with no completion strobes; the partial job is lost.
- FSM states: IDLE, START, SHIFT_MID, SHIFT_REM.
- IDLE:
  - work_ready=1.
  - On work_valid & work_ready, latch {midstate_in, block_in} into a 768-bit shift register, clear counter, go to START.
- START:
  - Lasts exactly one cycle.
  - start_found=1, shift_valid=0.
  - Go to SHIFT_MID.
- SHIFT_MID / SHIFT_REM:
  - shift_valid=1; shift_data = shift register [767:736].
  - Beat = shift_valid & rx_ready.
  - On a beat: shift register shifts left by WORD_W (zero fill) and the counter increments.
  - Without a beat: shift_data and the counter hold stable, regardless of how long rx_ready stays low.
- Transitions:
  - Beat with count==MID_WORDS-1 (7): midstate_shifts_done=1 in the same cycle (Mealy), then go to SHIFT_REM.
  - Beat with count==MID_WORDS+REM_WORDS-1 (23): remaining_shifts_done=1 in the same cycle, then go to IDLE.
  - The counter never wraps within a job; it is cleared on the next accept.
- Latency with rx_ready held high:
  - Accept at cycle T.
  - start_found at T+1.
  - Word 0 at T+2.
  - Word 23 at T+25.
  - work_ready again at T+26.
  - Minimum job period is 26 cycles.
- Constraints:
  - work_ready=0 outside IDLE; work_valid is ignored outside IDLE.
  - No back-to-back overlap of jobs.
  - Simultaneous strobes are impossible; each pulse occurs at most once per job.
  - midstate_in/block_in are sampled only on the accept cycle and may change afterwards.
  - rx_ready is a don't-care in IDLE and START.

Decomposition:
- Shared package miner_pkg holds:
  - WORD_W, MID_WORDS, REM_WORDS.
  - Derived MID_LAST=7 and ALL_LAST=23.
  - enum tx_state_t {IDLE, START, SHIFT_MID, SHIFT_REM}.
  - typedef word_t.
- Receiver timer constants reuse MID_LAST/ALL_LAST from the same package.
- Word index uses the team's existing generic counter module (width CNT_W), with:
  - enable = beat;
  - clear = accept or reset.
- The shift register and FSM stay in work_shift_tx; no further sub-module.

Test Plan:
1. Reset, then midstate words 0x00000001..0x00000008 and block words 0x00000101..0x00000110 with rx_ready=1:
   - start_found at T+1.
   - shift_data sequence 0x1..0x8, 0x101..0x110 on T+2..T+25.
   - midstate_shifts_done at T+9, remaining_shifts_done at T+25.
   - work_ready at T+26.
2. Same job, rx_ready low for 3 cycles before word 5 and for 1 cycle before word 23:
   - Data held stable during stalls; no words skipped or duplicated.
   - Strobes delayed by exactly 3 and 4 cycles respectively.
3. work_valid held high continuously for two jobs:
   - Second accept occurs only in IDLE at T+26.
   - Second start_found at T+27; no overlap.
4. n_rst low for one cycle during SHIFT_REM (after word 12):
   - Next cycle all outputs 0, work_ready=1.
   - No remaining_shifts_done pulse.
   - A new job then runs cleanly from word 0.
5. Change midstate_in/block_in every cycle after accept:
   - Transmitted words equal the values latched at accept.
6. Loopback against the receiving core's timer logic (driven by start_found and shift beats):
   - Its midstate/remaining done flags match this block's strobes cycle-for-cycle over 100 random-stall jobs.
